// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback stage: load-op and state encodings.
package wb_pkg;

  localparam int WB_DATA_WIDTH     = 32;
  localparam int WB_REG_ADDR_WIDTH = 5;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_LB   = 3'd1,
    LD_LBU  = 3'd2,
    LD_LH   = 3'd3,
    LD_LHU  = 3'd4,
    LD_LW   = 3'd5,
    LD_LWL  = 3'd6,
    LD_LWR  = 3'd7
  } load_op_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FULL  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// Little-endian load formatting: byte/halfword extract, extension, LWL/LWR merge.
module load_align
  import wb_pkg::*;
(
  input  logic [2:0]  load_op_i,
  input  logic [1:0]  addr_low_i,
  input  logic [31:0] mem_i,
  input  logic [31:0] rt_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = mem_i[{addr_low_i, 3'b000} +: 8];
  assign half_sel = mem_i[{addr_low_i[1], 4'b0000} +: 16];

  // LD_NONE passes the word through, so non-load results share this path
  always_comb begin
    result_o = mem_i;
    case (load_op_e'(load_op_i))
      LD_LB:   result_o = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  result_o = {24'h000000, byte_sel};
      LD_LH:   result_o = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  result_o = {16'h0000, half_sel};
      LD_LWL: begin
        case (addr_low_i)
          2'd0:    result_o = {mem_i[7:0],  rt_i[23:0]};
          2'd1:    result_o = {mem_i[15:0], rt_i[15:0]};
          2'd2:    result_o = {mem_i[23:0], rt_i[7:0]};
          default: result_o = mem_i;
        endcase
      end
      LD_LWR: begin
        case (addr_low_i)
          2'd0:    result_o = mem_i;
          2'd1:    result_o = {rt_i[31:24], mem_i[31:8]};
          2'd2:    result_o = {rt_i[31:16], mem_i[31:16]};
          default: result_o = {rt_i[31:8],  mem_i[31:24]};
        endcase
      end
      default: result_o = mem_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Memory/writeback stage: holds the retiring instruction, waits for load data,
// and drives the register file write port.
//   state    | meaning
//   ST_EMPTY | no entry held
//   ST_WAIT  | load captured, bus data not yet arrived
//   ST_FULL  | result complete, presented to the register file
module wb_stage
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH     = WB_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = WB_REG_ADDR_WIDTH
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ready,
  input  logic                      InValid,
  input  logic                      InWriteEnable,
  input  logic [REG_ADDR_WIDTH-1:0] InWriteAddress,
  input  logic [DATA_WIDTH-1:0]     InWriteData,
  input  logic [2:0]                InLoadOp,
  input  logic [1:0]                InAddrLow,
  input  logic [DATA_WIDTH-1:0]     InRtOld,
  input  logic [DATA_WIDTH-1:0]     RamReadData,
  input  logic                      RamDataValid,
  output logic                      StallRequest,
  output logic                      WriteEnable,
  output logic [REG_ADDR_WIDTH-1:0] WriteAddress,
  output logic [DATA_WIDTH-1:0]     WriteData
);

  wb_state_e                 state_q, state_d;
  logic                      we_q, we_d;
  logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic [2:0]                op_q, op_d;
  logic [1:0]                low_q, low_d;
  logic [DATA_WIDTH-1:0]     rt_q, rt_d;

  logic                      accept;
  logic [DATA_WIDTH-1:0]     mem_word;
  logic [DATA_WIDTH-1:0]     aligned;

  assign StallRequest = (state_q == ST_WAIT) && !RamDataValid;
  assign accept       = ready && !StallRequest;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      op_q    <= 3'(LD_NONE);
      low_q   <= 2'b00;
      rt_q    <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      op_q    <= op_d;
      low_q   <= low_d;
      rt_q    <= rt_d;
    end
  end

  // An accepting edge retires the held entry, so it outranks the WAIT data latch;
  // the latch only matters when a freeze blocks retirement.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    op_d    = op_q;
    low_d   = low_q;
    rt_d    = rt_q;
    if (accept) begin
      if (InValid) begin
        we_d   = InWriteEnable;
        addr_d = InWriteAddress;
        data_d = InWriteData;
        op_d   = InLoadOp;
        low_d  = InAddrLow;
        rt_d   = InRtOld;
        if ((InLoadOp == 3'(LD_NONE)) || !InWriteEnable) begin
          state_d = ST_FULL;
        end else begin
          state_d = ST_WAIT;
        end
      end else begin
        state_d = ST_EMPTY;
      end
    end else if ((state_q == ST_WAIT) && RamDataValid) begin
      state_d = ST_FULL;
      data_d  = RamReadData;
    end
  end

  assign mem_word = (state_q == ST_WAIT) ? RamReadData : data_q;

  load_align u_load_align (
    .load_op_i  (op_q),
    .addr_low_i (low_q),
    .mem_i      (mem_word),
    .rt_i       (rt_q),
    .result_o   (aligned)
  );

  assign WriteEnable  = ((state_q == ST_FULL) && we_q) ||
                        ((state_q == ST_WAIT) && RamDataValid);
  assign WriteAddress = WriteEnable ? addr_q  : '0;
  assign WriteData    = WriteEnable ? aligned : '0;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expected writes queued at issue, checked on commit.
module tb_wb_stage;
  import wb_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        ready;
  logic        InValid;
  logic        InWriteEnable;
  logic [4:0]  InWriteAddress;
  logic [31:0] InWriteData;
  logic [2:0]  InLoadOp;
  logic [1:0]  InAddrLow;
  logic [31:0] InRtOld;
  logic [31:0] RamReadData;
  logic        RamDataValid;
  logic        StallRequest;
  logic        WriteEnable;
  logic [4:0]  WriteAddress;
  logic [31:0] WriteData;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clock = ~clock;

  wb_stage dut (
    .clock          (clock),
    .reset          (reset),
    .ready          (ready),
    .InValid        (InValid),
    .InWriteEnable  (InWriteEnable),
    .InWriteAddress (InWriteAddress),
    .InWriteData    (InWriteData),
    .InLoadOp       (InLoadOp),
    .InAddrLow      (InAddrLow),
    .InRtOld        (InRtOld),
    .RamReadData    (RamReadData),
    .RamDataValid   (RamDataValid),
    .StallRequest   (StallRequest),
    .WriteEnable    (WriteEnable),
    .WriteAddress   (WriteAddress),
    .WriteData      (WriteData)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [1:0] k,
                                        input logic [31:0] rt, input logic [31:0] mem);
    logic [31:0] sh;
    int kk;
    kk = int'(k);
    case (op)
      3'd1: begin sh = mem >> (8 * kk); return {{24{sh[7]}}, sh[7:0]}; end
      3'd2: begin sh = mem >> (8 * kk); return {24'h0, sh[7:0]}; end
      3'd3: begin sh = mem >> (16 * (kk / 2)); return {{16{sh[15]}}, sh[15:0]}; end
      3'd4: begin sh = mem >> (16 * (kk / 2)); return {16'h0, sh[15:0]}; end
      3'd6: return (mem << (8 * (3 - kk))) | (rt & (32'hFFFFFFFF >> (8 * (kk + 1))));
      3'd7: return (mem >> (8 * kk)) | (rt & ~(32'hFFFFFFFF >> (8 * kk)));
      default: return mem;
    endcase
  endfunction

  // A write commits on the next rising edge when ready is high
  always @(negedge clock) begin
    if (reset && ready && WriteEnable) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {27'h0, WriteAddress}, 32'hFFFFFFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_addr", {27'h0, WriteAddress}, {27'h0, e.addr});
        chk("wr_data", WriteData, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic we, input logic [4:0] addr, input logic [31:0] data,
                       input logic [2:0] op, input logic [1:0] low, input logic [31:0] rt);
    InValid        = 1'b1;
    InWriteEnable  = we;
    InWriteAddress = addr;
    InWriteData    = data;
    InLoadOp       = op;
    InAddrLow      = low;
    InRtOld        = rt;
    tick();
    InValid        = 1'b0;
  endtask

  task automatic load_seq(input logic [4:0] addr, input logic [2:0] op, input logic [1:0] low,
                          input logic [31:0] rt, input logic [31:0] mem, input int waits,
                          input logic [31:0] expv);
    exp_t e;
    e.addr = addr;
    e.data = expv;
    exp_q.push_back(e);
    issue(1'b1, addr, 32'hDEAD0000, op, low, rt);
    for (int i = 0; i < waits; i++) begin
      @(negedge clock);
      chk("stall_wait", {31'h0, StallRequest}, 32'h1);
      tick();
    end
    RamDataValid = 1'b1;
    RamReadData  = mem;
    @(negedge clock);
    chk("stall_arrive", {31'h0, StallRequest}, 32'h0);
    chk("we_arrive", {31'h0, WriteEnable}, 32'h1);
    tick();
    RamDataValid = 1'b0;
    RamReadData  = 32'h0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [31:0] rt, mem;
    logic [2:0]  op;
    logic [1:0]  k;

    reset = 1'b0; ready = 1'b1; InValid = 1'b0; InWriteEnable = 1'b0;
    InWriteAddress = '0; InWriteData = '0; InLoadOp = '0; InAddrLow = '0;
    InRtOld = '0; RamReadData = '0; RamDataValid = 1'b0;
    #2;
    chk("rst_we", {31'h0, WriteEnable}, 32'h0);
    chk("rst_wa", {27'h0, WriteAddress}, 32'h0);
    chk("rst_wd", WriteData, 32'h0);
    chk("rst_stall", {31'h0, StallRequest}, 32'h0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // non-load retire
    e.addr = 5'd3; e.data = 32'h12345678; exp_q.push_back(e);
    issue(1'b1, 5'd3, 32'h12345678, 3'(LD_NONE), 2'd0, 32'h0);
    @(negedge clock);
    chk("nl_stall", {31'h0, StallRequest}, 32'h0);
    chk("nl_we", {31'h0, WriteEnable}, 32'h1);
    tick();
    chk("nl_empty_we", {31'h0, WriteEnable}, 32'h0);

    // LB with bus wait
    load_seq(5'd5, 3'(LD_LB), 2'd2, 32'h0, 32'h00AB0000, 2, 32'hFFFFFFAB);

    // merge cases with fixed expectations
    load_seq(5'd6, 3'(LD_LWL), 2'd1, 32'hAABBCCDD, 32'h11223344, 0, 32'h3344CCDD);
    load_seq(5'd7, 3'(LD_LWR), 2'd2, 32'hAABBCCDD, 32'h11223344, 1, 32'hAABB1122);
    load_seq(5'd8, 3'(LD_LHU), 2'd2, 32'hAABBCCDD, 32'h11223344, 0, 32'h00001122);
    load_seq(5'd9, 3'(LD_LH),  2'd0, 32'h0, 32'h0000F00D, 0, 32'hFFFFF00D);
    load_seq(5'd10, 3'(LD_LBU), 2'd3, 32'h0, 32'h9A000000, 0, 32'h0000009A);

    // random loads against the reference model
    for (int i = 0; i < 12; i++) begin
      op  = 3'($urandom_range(1, 7));
      k   = 2'($urandom_range(0, 3));
      rt  = $urandom;
      mem = $urandom;
      load_seq(5'($urandom_range(1, 31)), op, k, rt, mem, int'($urandom_range(0, 2)),
               model(op, k, rt, mem));
    end

    // freeze while data arrives
    e.addr = 5'd7; e.data = 32'hCAFEF00D; exp_q.push_back(e);
    issue(1'b1, 5'd7, 32'h0, 3'(LD_LW), 2'd2, 32'h0);
    ready = 1'b0;
    RamDataValid = 1'b1; RamReadData = 32'hCAFEF00D;
    tick();
    RamDataValid = 1'b0; RamReadData = 32'h0;
    InValid = 1'b1; InWriteEnable = 1'b1; InWriteAddress = 5'd20;
    InWriteData = 32'h0BADBAD0; InLoadOp = 3'(LD_NONE);
    @(negedge clock);
    chk("frz_we", {31'h0, WriteEnable}, 32'h1);
    chk("frz_wd", WriteData, 32'hCAFEF00D);
    chk("frz_stall", {31'h0, StallRequest}, 32'h0);
    tick();
    chk("frz_wa", {27'h0, WriteAddress}, 32'd7);
    InValid = 1'b0;
    ready = 1'b1;
    tick();
    chk("frz_after_we", {31'h0, WriteEnable}, 32'h0);

    // async reset while a load is pending
    issue(1'b1, 5'd9, 32'h0, 3'(LD_LW), 2'd0, 32'h0);
    #1;
    RamDataValid = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    chk("arst_we", {31'h0, WriteEnable}, 32'h0);
    chk("arst_wa", {27'h0, WriteAddress}, 32'h0);
    chk("arst_stall", {31'h0, StallRequest}, 32'h0);
    tick();
    reset = 1'b1;
    RamDataValid = 1'b1; RamReadData = 32'h55555555;
    @(negedge clock);
    chk("arst_post_we", {31'h0, WriteEnable}, 32'h0);
    tick();
    RamDataValid = 1'b0; RamReadData = 32'h0;

    // back-to-back non-loads, including one that does not write
    for (int a = 1; a <= 3; a++) begin
      e.addr = 5'(a); e.data = 32'hA0000000 + 32'(a); exp_q.push_back(e);
      InValid = 1'b1; InWriteEnable = 1'b1; InWriteAddress = 5'(a);
      InWriteData = 32'hA0000000 + 32'(a); InLoadOp = 3'(LD_NONE);
      tick();
    end
    InValid = 1'b1; InWriteEnable = 1'b0; InWriteAddress = 5'd12; InWriteData = 32'h1;
    tick();
    InValid = 1'b0;
    @(negedge clock);
    chk("b2b_nowrite_we", {31'h0, WriteEnable}, 32'h0);
    tick();
    chk("b2b_idle_we", {31'h0, WriteEnable}, 32'h0);
    tick();

    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Memory/writeback pipeline stage that sits directly upstream of the register file and drives its single write port (WriteEnable, WriteAddress, WriteData).
- Captures the retiring instruction from the memory stage and waits, if needed, for load data from the data bus.
- Performs byte/halfword extraction, sign/zero extension and LWL/LWR merging, then presents the final value to the register file.
- Raises StallRequest while a load's data is outstanding.

Parameters:
- DATA_WIDTH, 32, register/data width; only 32 is supported.
- REG_ADDR_WIDTH, 5, register index width.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- ready  in  1  global advance enable; 0 freezes the stage.
- InValid  in  1  memory stage presents a retiring instruction.
- InWriteEnable  in  1  instruction writes a register.
- InWriteAddress  in  5  destination register index.
- InWriteData  in  32  ALU result (non-load instructions).
- InLoadOp  in  3  load type, encoding from the package.
- InAddrLow  in  2  byte offset of the load address.
- InRtOld  in  32  old rt value, used for the LWL/LWR merge.
- RamReadData  in  32  data bus read word.
- RamDataValid  in  1  RamReadData is valid this cycle.
- StallRequest  out  1  upstream must hold its contents.
- WriteEnable  out  1  register file write enable.
- WriteAddress  out  5  register file write index.
- WriteData  out  32  register file write data.

Behaviour:
- Reset: asynchronous, active-low. While reset=0, all state is cleared, state=EMPTY, and WriteEnable, WriteAddress, WriteData and StallRequest are all 0. No other reset value is permitted.
- States:
  - EMPTY: no entry held.
  - WAIT: load captured, data not yet arrived.
  - FULL: result complete.
- Accept condition: accept = ready && !StallRequest. An entry is captured only on an edge where accept=1 and InValid=1.
  - Capture is allowed from any state; the old entry retires on that same edge.
  - accept=1 with InValid=0 sends the stage to EMPTY.
- On capture:
  - LoadOp=NONE, or InWriteEnable=0 → FULL.
  - Otherwise → WAIT.
- WAIT:
  - RamDataValid=1 sampled on an edge → latch RamReadData into the data buffer, go to FULL.
  - This happens regardless of ready, so data arriving during a global freeze is never lost.
- StallRequest = (state==WAIT) && !RamDataValid. This is combinational, so a same-cycle RamDataValid releases the stall.
- ready=0: no capture and no retire. Only the WAIT→FULL data latch may occur.
- Outputs are combinational from the held entry, plus RamReadData in the bypass case:
  - WriteEnable = 1 when state==FULL and the entry has WriteEnable set.
  - WriteEnable = 1 when state==WAIT and RamDataValid=1 (same-cycle bypass).
  - WriteEnable = 0 otherwise.
  - WriteAddress and WriteData are 0 whenever WriteEnable=0.
- A FULL entry is presented for exactly the cycles in which it is held; the register file commits it on the next edge with ready=1.
- Address 0 is passed through unchanged; the register file discards it.
- Load formatting (little-endian, k = AddrLow):
  - LB / LBU: byte k, sign- / zero-extended.
  - LH / LHU: halfword AddrLow[1], sign- / zero-extended. AddrLow[0] is ignored; alignment faults are trapped upstream.
  - LW: full word; AddrLow is ignored.
  - LWL:
    - k=0: {mem[7:0], rt[23:0]}
    - k=1: {mem[15:0], rt[15:0]}
    - k=2: {mem[23:0], rt[7:0]}
    - k=3: mem
  - LWR:
    - k=0: mem
    - k=1: {rt[31:24], mem[31:8]}
    - k=2: {rt[31:16], mem[31:16]}
    - k=3: {rt[31:8], mem[31:24]}
- Latency: non-load = 1 cycle from capture to write presentation; load = capture + bus wait.
- Reset asserted mid-WAIT: the pending load is abandoned and no write is issued after reset deasserts.

Decomposition:
- Package wb_pkg holds:
  - LoadOp encoding: NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, LWL=6, LWR=7.
  - State encoding: EMPTY, WAIT, FULL.
  - DATA_WIDTH / REG_ADDR_WIDTH defaults.
- Sub-module load_align: purely combinational; inputs LoadOp, AddrLow, mem word and rt; output the formatted 32-bit value.

Test Plan:
- Non-load retire:
  - Stimulus: capture InWriteAddress=3, InWriteData=0x12345678 with ready=1.
  - Response: next cycle WriteEnable=1, WriteAddress=3, WriteData=0x12345678; StallRequest=0 throughout.
- LB sign extension with wait:
  - Stimulus: LB, AddrLow=2; RamReadData=0x00AB0000 arrives 3 cycles after capture.
  - Response: StallRequest=1 for 2 cycles and 0 in the arrival cycle; WriteData=0xFFFFFFAB with WriteEnable=1 in the arrival cycle.
- LWL / LWR merge:
  - Stimulus: rt=0xAABBCCDD, mem=0x11223344.
  - Response: LWL k=1 → 0x3344CCDD; LWR k=2 → 0xAABB1122; LHU k=2 → 0x00001122.
- Freeze during data arrival:
  - Stimulus: ready=0 while RamDataValid pulses one cycle with 0xCAFEF00D (LW); ready returns 1 two cycles later.
  - Response: state reaches FULL; WriteData=0xCAFEF00D is held and committed on the first ready=1 edge; no new capture occurs during the freeze.
- Async reset mid-WAIT:
  - Stimulus: pull reset low between clock edges while a load is pending.
  - Response: all outputs are 0 immediately; after release, state=EMPTY and no write occurs even if RamDataValid then pulses.
- Back-to-back:
  - Stimulus: three non-load instructions on consecutive cycles to addresses 1, 2, 3.
  - Response: consecutive writes to 1, 2, 3; InValid=0 afterwards gives WriteEnable=0.
